// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: decodes observed lamps, verifies phase order
// and phase durations, and reports illegal/sequence/timing errors.
module traffic_light_monitor #(
   parameter int GREEN_TIME  = 10,
   parameter int YELLOW_TIME = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NS_red,
   input  logic        NS_yellow,
   input  logic        NS_green,
   input  logic        EW_red,
   input  logic        EW_yellow,
   input  logic        EW_green,
   output logic [1:0]  phase,
   output logic        locked,
   output logic        err_illegal,
   output logic        err_sequence,
   output logic        err_timing,
   output logic        fault,
   output logic [1:0]  err_code,
   output logic [15:0] cycle_count
);

   localparam logic [1:0] ST_ACQUIRE = 2'd0;
   localparam logic [1:0] ST_TRACK   = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

   localparam logic [1:0] CODE_ILLEGAL  = 2'd1;
   localparam logic [1:0] CODE_SEQUENCE = 2'd2;
   localparam logic [1:0] CODE_TIMING   = 2'd3;

   // Expected dwell per phase, one wider than dwell so huge parameters never alias.
   localparam logic [16:0] GREEN_LEN  = 17'(GREEN_TIME + 1);
   localparam logic [16:0] YELLOW_LEN = 17'(YELLOW_TIME + 1);

   logic [1:0]  state;
   logic [15:0] dwell;
   logic        seen;

   logic [5:0]  lamps;
   logic        legal;
   logic [1:0]  dec_phase;
   logic        is_succ;
   logic        changed;
   logic        at_len;

   logic [1:0]  nxt_state;
   logic [15:0] nxt_dwell;
   logic        hit_ill;
   logic        hit_seq;
   logic        hit_tim;
   logic        any_err;
   logic        cnt_inc;

   assign lamps = {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green};

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      legal     = 1'b1;
      dec_phase = 2'd0;
      case (lamps)
         6'b001_100: dec_phase = 2'd0;
         6'b010_100: dec_phase = 2'd1;
         6'b100_001: dec_phase = 2'd2;
         6'b100_010: dec_phase = 2'd3;
         default:    legal     = 1'b0;
      endcase
   end

   assign is_succ = (dec_phase == (phase + 2'd1));
   assign changed = seen && (dec_phase != phase);
   // Odd phases are the yellow ones.
   assign at_len  = ({1'b0, dwell} == (phase[0] ? YELLOW_LEN : GREEN_LEN));

   // Illegal masks everything else; sequence and timing are exclusive by branch.
   always_comb begin
      nxt_state = state;
      nxt_dwell = dwell;
      hit_ill   = 1'b0;
      hit_seq   = 1'b0;
      hit_tim   = 1'b0;
      cnt_inc   = 1'b0;
      if (!legal) begin
         hit_ill = 1'b1;
      end else begin
         case (state)
            ST_ACQUIRE: begin
               if (changed) begin
                  if (is_succ) begin
                     nxt_state = ST_TRACK;
                     nxt_dwell = 16'd1;
                  end else begin
                     hit_seq = 1'b1;
                  end
               end
            end
            ST_TRACK: begin
               if (!changed) begin
                  if (at_len) hit_tim = 1'b1;
                  else if (dwell != 16'hFFFF) nxt_dwell = dwell + 16'd1;
               end else if (is_succ) begin
                  if (!at_len) begin
                     hit_tim = 1'b1;
                  end else begin
                     nxt_dwell = 16'd1;
                     cnt_inc   = (phase == 2'd3);
                  end
               end else begin
                  hit_seq = 1'b1;
               end
            end
            default: begin
               // Dwell is meaningless after a fault; order is still checkable.
               if (changed && !is_succ) hit_seq = 1'b1;
            end
         endcase
      end
      any_err = hit_ill | hit_seq | hit_tim;
      if (any_err) nxt_state = ST_FAULT;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_ACQUIRE;
         dwell        <= 16'd0;
         seen         <= 1'b0;
         phase        <= 2'd0;
         locked       <= 1'b0;
         err_illegal  <= 1'b0;
         err_sequence <= 1'b0;
         err_timing   <= 1'b0;
         fault        <= 1'b0;
         err_code     <= 2'd0;
         cycle_count  <= 16'd0;
      end else begin
         state        <= nxt_state;
         dwell        <= nxt_dwell;
         locked       <= (nxt_state == ST_TRACK);
         err_illegal  <= hit_ill;
         err_sequence <= hit_seq;
         err_timing   <= hit_tim;
         if (legal) begin
            phase <= dec_phase;
            seen  <= 1'b1;
         end
         if (any_err) begin
            fault <= 1'b1;
            if (err_code == 2'd0)
               err_code <= hit_ill ? CODE_ILLEGAL : (hit_seq ? CODE_SEQUENCE : CODE_TIMING);
         end
         if (cnt_inc) cycle_count <= cycle_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus
// randomized lamp streams compared against a rule-level reference model.
module tb_traffic_light_monitor;

   localparam int GL = 11;  // green phase samples (GREEN_TIME+1)
   localparam int YL = 4;   // yellow phase samples (YELLOW_TIME+1)
   localparam int M_ACQ = 0, M_TRK = 1, M_FLT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        NS_red = 1'b0, NS_yellow = 1'b0, NS_green = 1'b0;
   logic        EW_red = 1'b0, EW_yellow = 1'b0, EW_green = 1'b0;
   logic [1:0]  phase;
   logic        locked, err_illegal, err_sequence, err_timing, fault;
   logic [1:0]  err_code;
   logic [15:0] cycle_count;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_mode, m_phase, m_run, m_code, m_cycles;
   bit m_seen, m_fault, m_ill, m_seq, m_tim;

   // lamp generator state
   int g_phase, g_left;

   traffic_light_monitor #(.GREEN_TIME(10), .YELLOW_TIME(3)) dut (
      .clk(clk), .rst(rst),
      .NS_red(NS_red), .NS_yellow(NS_yellow), .NS_green(NS_green),
      .EW_red(EW_red), .EW_yellow(EW_yellow), .EW_green(EW_green),
      .phase(phase), .locked(locked),
      .err_illegal(err_illegal), .err_sequence(err_sequence), .err_timing(err_timing),
      .fault(fault), .err_code(err_code), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] pat(input int p);
      case (p)
         0: return 6'b001_100;
         1: return 6'b010_100;
         2: return 6'b100_001;
         default: return 6'b100_010;
      endcase
   endfunction

   function automatic int plen(input int p);
      return (p % 2 == 0) ? GL : YL;
   endfunction

   function automatic logic [24:0] dut_vec();
      return {phase, locked, err_illegal, err_sequence, err_timing, fault, err_code, cycle_count};
   endfunction

   function automatic logic [24:0] exp_vec();
      return {2'(m_phase), (m_mode == M_TRK), m_ill, m_seq, m_tim, m_fault, 2'(m_code), 16'(m_cycles)};
   endfunction

   task automatic model_update(input logic r, input logic [5:0] p);
      int  np;
      bit  nxt, chg;
      m_ill = 0; m_seq = 0; m_tim = 0;
      if (!r) begin
         m_mode = M_ACQ; m_phase = 0; m_run = 0; m_code = 0; m_cycles = 0;
         m_seen = 0; m_fault = 0;
         return;
      end
      np = -1;
      for (int k = 0; k < 4; k++) if (pat(k) == p) np = k;
      if (np < 0) begin
         m_ill = 1;
      end else begin
         nxt = ((m_phase + 1) % 4 == np);
         chg = m_seen && (np != m_phase);
         if (m_mode == M_ACQ) begin
            if (chg) begin
               if (nxt) begin m_mode = M_TRK; m_run = 1; end
               else m_seq = 1;
            end
         end else if (m_mode == M_TRK) begin
            if (!chg) begin
               if (m_run == plen(m_phase)) m_tim = 1;
               else m_run++;
            end else if (nxt) begin
               if (m_run != plen(m_phase)) m_tim = 1;
               else begin
                  m_run = 1;
                  if (m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
               end
            end else begin
               m_seq = 1;
            end
         end else if (chg && !nxt) begin
            m_seq = 1;
         end
         m_phase = np;
         m_seen  = 1;
      end
      if (m_ill || m_seq || m_tim) begin
         m_mode = M_FLT;
         if (!m_fault) m_code = m_ill ? 1 : (m_seq ? 2 : 3);
         m_fault = 1;
      end
   endtask

   // Drive one sample, clock it in, and advance the model; outputs are read #1 after the edge.
   task automatic tick(input logic r, input logic [5:0] p);
      rst = r;
      {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green} = p;
      @(posedge clk);
      #1;
      model_update(r, p);
   endtask

   task automatic play(input logic r, input logic [5:0] p, input string tag);
      tick(r, p);
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL %s t=%0t: dut=%h model=%h", tag, $time, dut_vec(), exp_vec());
      end
   endtask

   task automatic gen_next(output logic [5:0] p);
      p = pat(g_phase);
      g_left--;
      if (g_left == 0) begin
         g_phase = (g_phase + 1) % 4;
         g_left  = plen(g_phase);
      end
   endtask

   // Reset, then play a clean sequence until locked and about to start a fresh green NS phase.
   task automatic align(input string tag);
      logic [5:0] p;
      int n;
      play(1'b0, pat(0), tag);
      play(1'b0, pat(0), tag);
      g_phase = 0; g_left = GL; n = 0;
      while (!(m_mode == M_TRK && g_phase == 0 && g_left == GL) && n < 100) begin
         gen_next(p);
         play(1'b1, p, tag);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s: no lock within 100 cycles, locked=%b required 1", tag, locked);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) play(1'b0, 6'($urandom_range(0, 63)), "reset");
      checks++;
      if ({phase, locked, fault, err_code, cycle_count} !== 22'd0) begin
         errors++;
         $display("FAIL reset_zero: got %h required 0", {phase, locked, fault, err_code, cycle_count});
      end
   endtask

   task automatic test_normal();
      logic [5:0] p;
      play(1'b0, pat(0), "normal");
      g_phase = 0; g_left = GL;
      for (int i = 0; i < 1000; i++) begin
         gen_next(p);
         play(1'b1, p, "normal");
         if (i == 10 || i == 11) begin
            checks++;
            if (locked !== (i == 11)) begin
               errors++;
               $display("FAIL lock_edge sample %0d: locked=%b required %b", i + 1, locked, (i == 11));
            end
         end
      end
      // first NS green sample of cycle k is sample 30k+1
      checks++;
      if (cycle_count !== 16'((1000 - 1) / 30) || fault !== 1'b0) begin
         errors++;
         $display("FAIL normal_count: cycle_count=%0d fault=%b required %0d, 0",
                  cycle_count, fault, (1000 - 1) / 30);
      end
   endtask

   task automatic test_random_start();
      logic [5:0] p;
      for (int r = 0; r < 4; r++) begin
         play(1'b0, pat(0), "rand_start");
         g_phase = $urandom_range(0, 3);
         g_left  = $urandom_range(1, plen(g_phase));
         for (int i = 0; i < 150; i++) begin
            gen_next(p);
            play(1'b1, p, "rand_start");
         end
      end
   endtask

   task automatic test_illegal();
      align("illegal");
      for (int i = 0; i < 3; i++) play(1'b1, pat(0), "illegal");
      play(1'b1, 6'b001_001, "illegal");
      checks++;
      if ({err_illegal, fault, err_code, locked} !== 5'b1_1_01_0) begin
         errors++;
         $display("FAIL illegal_flags: ill/fault/code/locked=%b required 11010",
                  {err_illegal, fault, err_code, locked});
      end
      play(1'b1, pat(0), "illegal_after");
      checks++;
      if (err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pulse: err_illegal=%b required 0", err_illegal);
      end
   endtask

   task automatic test_sequence();
      align("sequence");
      for (int i = 0; i < GL; i++) play(1'b1, pat(0), "sequence");
      play(1'b1, pat(2), "sequence");
      checks++;
      if ({err_sequence, err_code, locked} !== 4'b1_10_0) begin
         errors++;
         $display("FAIL sequence_flags: seq/code/locked=%b required 1100", {err_sequence, err_code, locked});
      end
   endtask

   task automatic test_timing();
      align("timing_short");
      for (int i = 0; i < 5; i++) play(1'b1, pat(0), "timing_short");
      play(1'b1, pat(1), "timing_short");
      checks++;
      if ({err_timing, err_code} !== 3'b1_11) begin
         errors++;
         $display("FAIL timing_short: tim/code=%b required 111", {err_timing, err_code});
      end
      align("timing_over");
      for (int i = 0; i < GL; i++) play(1'b1, pat(0), "timing_over");
      for (int i = 0; i < 5; i++) begin
         play(1'b1, pat(1), "timing_over");
         checks++;
         if (err_timing !== (i == 4)) begin
            errors++;
            $display("FAIL timing_over sample %0d: err_timing=%b required %b", i + 1, err_timing, (i == 4));
         end
      end
   endtask

   task automatic test_priority();
      align("priority");
      for (int i = 0; i < GL; i++) play(1'b1, pat(0), "priority");
      for (int i = 0; i < YL; i++) play(1'b1, pat(1), "priority");
      play(1'b1, 6'b000_000, "priority");
      checks++;
      if ({err_illegal, err_sequence, err_timing, err_code} !== 5'b100_01) begin
         errors++;
         $display("FAIL priority: ill/seq/tim/code=%b required 10001",
                  {err_illegal, err_sequence, err_timing, err_code});
      end
   endtask

   task automatic test_recover();
      logic [5:0] p;
      play(1'b1, 6'b111_111, "recover");
      play(1'b0, pat(0), "recover");
      checks++;
      if ({fault, err_code, cycle_count} !== 19'd0) begin
         errors++;
         $display("FAIL recover_clear: fault/code/count=%h required 0", {fault, err_code, cycle_count});
      end
      g_phase = 0; g_left = GL;
      for (int i = 0; i < 70; i++) begin
         gen_next(p);
         play(1'b1, p, "recover");
      end
      checks++;
      if ({locked, fault, cycle_count} !== {2'b10, 16'd2}) begin
         errors++;
         $display("FAIL recover_relock: locked/fault/count=%h required %h",
                  {locked, fault, cycle_count}, {2'b10, 16'd2});
      end
   endtask

   task automatic test_fuzz();
      logic [5:0] p;
      play(1'b0, pat(0), "fuzz");
      g_phase = 0; g_left = GL;
      for (int i = 0; i < 2000; i++) begin
         gen_next(p);
         if ($urandom_range(0, 59) == 0) p = 6'($urandom_range(0, 63));
         else if ($urandom_range(0, 59) == 0) p = pat($urandom_range(0, 3));
         play(($urandom_range(0, 149) != 0), p, "fuzz");
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_random_start();
      test_illegal();
      test_sequence();
      test_timing();
      test_priority();
      test_recover();
      test_fuzz();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
